// File: rtl/bcd_scoreboard.sv
// bcd_scoreboard: game score held directly in packed BCD, with a synchronised/edge-detected
// point input, a pending-event counter and saturation at all-9s. Define HIGH_SCORE_EN for high-score tracking.
module bcd_scoreboard #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned PEND_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                point_add,
  input  logic                bird_die,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic                busy,
  output logic                saturated,
  output logic                pend_ovf,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic                new_high
);

  localparam int unsigned         IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [PEND_W-1:0]   PEND_MAX  = '1;

  typedef enum logic {IDLE, INC} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [4*DIGITS-1:0] score_n;
  logic [PEND_W-1:0]   pend, pend_n;
  logic                ovf_n;
  logic                s1, s2, s3;
  logic                ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= point_add;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      score_bcd <= '0;
      pend      <= '0;
      pend_ovf  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      score_bcd <= score_n;
      pend      <= pend_n;
      pend_ovf  <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    score_n = score_bcd;
    pend_n  = pend;
    ovf_n   = pend_ovf;
    if (bird_die) begin
      state_n = IDLE;
      idx_n   = '0;
      score_n = '0;
      pend_n  = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend != '0) begin
            if (saturated) begin
              pend_n = '0;
            end else begin
              state_n = INC;
              idx_n   = '0;
              pend_n  = pend - PEND_W'(1);
            end
          end
        end
        INC: begin
          // one digit per cycle: a 9 becomes 0 and the carry moves up, otherwise finish
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
              if (score_bcd[4*i +: 4] == 4'd9) begin
                score_n[4*i +: 4] = 4'd0;
                idx_n             = idx + IDX_W'(1);
              end else begin
                score_n[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
                state_n           = IDLE;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
      // an event is only dropped if there is no room after this cycle's dequeue/discard
      if (ev) begin
        if (pend_n == PEND_MAX) ovf_n = 1'b1;
        else                    pend_n = pend_n + PEND_W'(1);
      end
    end
  end

  always_comb begin
    busy      = (state == INC) || (pend != '0);
    saturated = (score_bcd == ALL_NINES);
  end

`ifdef HIGH_SCORE_EN
  logic                die_q;
  logic [4*DIGITS-1:0] high_q;
  logic                new_high_q;

  // compared against the pre-clear score on the first cycle of bird_die
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      die_q      <= 1'b0;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      die_q      <= bird_die;
      new_high_q <= 1'b0;
      if (bird_die && !die_q && (score_bcd > high_q)) begin
        high_q     <= score_bcd;
        new_high_q <= 1'b1;
      end
    end
  end

  always_comb begin
    high_bcd = high_q;
    new_high = new_high_q;
  end
`else
  always_comb begin
    high_bcd = '0;
    new_high = 1'b0;
  end
`endif

endmodule
